ex_alu_muldiv: RTL

//  EX-stage execution unit for the MIPS32 pipeline; parametrised successor of the single-cycle ALU.

---
 rtl/ex_alu_muldiv.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ex_alu_muldiv.sv
// EX-stage execution unit: single-cycle ALU plus an iterative radix-2 multiply/divide
// engine that owns the HI/LO registers and freezes the pipeline while it iterates.
module ex_alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start_EX,
    input  logic             Flush_EX,
    input  logic [WIDTH-1:0] Read_Data_1_EX,
    input  logic [WIDTH-1:0] ALU_Data_2_EX,
    input  logic [3:0]       ALU_Control_EX,
    output logic [WIDTH-1:0] ALU_Result_EX,
    output logic             Zero_EX,
    output logic             Overflow_EX,
    output logic             Stall_EX
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ((~v) + (2*WIDTH)'(1)) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]   add_res, sub_res;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quo, fix_rem;
    logic               issue, signed_op;

    // Single-cycle datapath
    assign a_s     = Read_Data_1_EX;
    assign b_s     = ALU_Data_2_EX;
    assign add_res = Read_Data_1_EX + ALU_Data_2_EX;
    assign sub_res = Read_Data_1_EX - ALU_Data_2_EX;

    always_comb begin
        ALU_Result_EX = '0;
        Overflow_EX   = 1'b0;
        case (ALU_Control_EX)
            4'b0000: ALU_Result_EX = Read_Data_1_EX & ALU_Data_2_EX;
            4'b0001: ALU_Result_EX = Read_Data_1_EX | ALU_Data_2_EX;
            4'b0010: begin
                ALU_Result_EX = add_res;
                Overflow_EX   = (Read_Data_1_EX[WIDTH-1] == ALU_Data_2_EX[WIDTH-1]) &&
                                (add_res[WIDTH-1] != Read_Data_1_EX[WIDTH-1]);
            end
            4'b0011: ALU_Result_EX = Read_Data_1_EX ^ ALU_Data_2_EX;
            4'b0100: ALU_Result_EX = ~(Read_Data_1_EX | ALU_Data_2_EX);
            4'b0101: ALU_Result_EX = {{(WIDTH-1){1'b0}}, (Read_Data_1_EX < ALU_Data_2_EX)};
            4'b0110: begin
                ALU_Result_EX = sub_res;
                Overflow_EX   = (Read_Data_1_EX[WIDTH-1] != ALU_Data_2_EX[WIDTH-1]) &&
                                (sub_res[WIDTH-1] != Read_Data_1_EX[WIDTH-1]);
            end
            4'b0111: ALU_Result_EX = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'b1100: ALU_Result_EX = hi_q;
            4'b1101: ALU_Result_EX = lo_q;
            default: ALU_Result_EX = '0;
        endcase
    end

    assign Zero_EX = (ALU_Result_EX == '0);

    // Iteration step: shift-add multiply and restoring divide share acc_q.
    // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign fix_prod = apply_sign_2w(acc_q, neg_res_q);
    assign fix_quo  = apply_sign_w(acc_q[WIDTH-1:0], neg_res_q);
    assign fix_rem  = apply_sign_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

    // Issue is gated by reset so a held mul/div op cannot re-raise the stall while in reset.
    assign issue     = Reset_n && Start_EX && !Flush_EX && (ALU_Control_EX[3:2] == 2'b10);
    assign signed_op = ~ALU_Control_EX[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        Stall_EX  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    Stall_EX  = 1'b1;
                    acc_d     = {{WIDTH{1'b0}}, magnitude(Read_Data_1_EX, signed_op)};
                    opb_d     = magnitude(ALU_Data_2_EX, signed_op);
                    is_div_d  = ALU_Control_EX[1];
                    neg_res_d = signed_op && (Read_Data_1_EX[WIDTH-1] ^ ALU_Data_2_EX[WIDTH-1]);
                    neg_rem_d = signed_op && Read_Data_1_EX[WIDTH-1];
                    div0_d    = (ALU_Data_2_EX == '0);
                    cnt_d     = CNT_LOAD;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                Stall_EX = 1'b1;
                if (Flush_EX) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (div_diff[WIDTH])
                            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        else
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE)
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Flush_EX) begin
                    if (is_div_q) begin
                        lo_d = div0_q ? '1 : fix_quo;
                        hi_d = fix_rem;
                    end else begin
                        hi_d = fix_prod[2*WIDTH-1:WIDTH];
                        lo_d = fix_prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working datapath; always reloaded at issue, so no reset needed
    always_ff @(posedge Clk) begin
        acc_q     <= acc_d;
        opb_q     <= opb_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        div0_q    <= div0_d;
    end

endmodule
